// File: rtl/snn_pkg.sv
// Shared types and helpers for the time-multiplexed spiking layer.
package snn_pkg;

    // Layer sequencer states.
    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StUpdate,
        StDone
    } lif_state_e;

    // Index width for a table of n entries; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Signed add of a and b, clamped to the range of a width-bit signed value.
    function automatic longint sat_add(input longint a, input longint b,
                                       input int unsigned width);
        longint hi;
        longint lo;
        longint s;
        longint r;
        hi = (longint'(1) <<< (width - 1)) - 1;
        lo = -hi - 1;
        s  = a + b;
        if (s > hi) begin
            r = hi;
        end else if (s < lo) begin
            r = lo;
        end else begin
            r = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/lif_update.sv
// Per-neuron leak/integrate/fire decision, shared by all neurons of the layer.
module lif_update
    import snn_pkg::*;
#(
    parameter int unsigned POT_SIZE   = 16,
    parameter int          THRESH     = 10,
    parameter int          RESET      = 0,
    parameter int unsigned LEAK_SHIFT = 0,
    parameter int unsigned REFRAC     = 2,
    parameter int unsigned WTA        = 0,
    parameter int unsigned REFRAC_W   = 2
) (
    input  logic signed [POT_SIZE-1:0] v,
    input  logic signed [POT_SIZE-1:0] sum,
    input  logic        [REFRAC_W-1:0] refrac,
    input  logic                       inhibit,     // a lower-index neuron fired this step
    output logic signed [POT_SIZE-1:0] v_next,
    output logic        [REFRAC_W-1:0] refrac_next,
    output logic                       spike
);

    localparam logic signed [POT_SIZE-1:0] THRESH_V = POT_SIZE'(THRESH);
    localparam logic signed [POT_SIZE-1:0] RESET_V  = POT_SIZE'(RESET);

    logic signed [POT_SIZE-1:0] leak;
    logic signed [POT_SIZE-1:0] decayed;
    logic signed [POT_SIZE-1:0] integ;

    // Leak, saturating integrate, then refractory / inhibition / threshold priority.
    always_comb begin
        // Arithmetic shift so negative potentials decay toward zero; shift 0 means no leak.
        leak = '0;
        if (LEAK_SHIFT != 0) begin
            leak = v >>> LEAK_SHIFT;
        end
        // v - (v >>> k) only shrinks |v|, so only the final add can overflow.
        decayed = v - leak;
        integ   = POT_SIZE'(sat_add(longint'(decayed), longint'(sum), POT_SIZE));

        v_next      = integ;
        refrac_next = refrac;
        spike       = 1'b0;
        if (refrac != '0) begin
            refrac_next = refrac - REFRAC_W'(1);
            v_next      = RESET_V;
        end else if ((WTA != 0) && inhibit) begin
            v_next = RESET_V;
        end else if (integ >= THRESH_V) begin
            spike       = 1'b1;
            v_next      = RESET_V;
            refrac_next = REFRAC_W'(REFRAC);
        end
    end

endmodule

// File: rtl/lif_layer_tm.sv
// Time-multiplexed LIF layer: one accumulator walks every synapse of every neuron per step.
module lif_layer_tm
    import snn_pkg::*;
#(
    parameter int unsigned NUM_INPUTS  = 4,
    parameter int unsigned NUM_OUTPUTS = 4,
    parameter int unsigned WEIGHT_SIZE = 8,
    parameter int unsigned POT_SIZE    = 16,
    parameter int          THRESH      = 10,
    parameter int          RESET       = 0,
    parameter int unsigned LEAK_SHIFT  = 0,
    parameter int unsigned REFRAC      = 2,
    parameter int unsigned WTA         = 0,
    localparam int unsigned NW = idx_w(NUM_OUTPUTS),
    localparam int unsigned IW = idx_w(NUM_INPUTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          step_valid,
    output logic                          step_ready,
    input  logic [NUM_INPUTS-1:0]         spike_in,
    output logic [NUM_OUTPUTS-1:0]        spike_out,
    output logic                          spike_valid,
    input  logic                          wr_en,
    input  logic [NW-1:0]                 wr_neuron,
    input  logic [IW-1:0]                 wr_input,
    input  logic signed [WEIGHT_SIZE-1:0] wr_data
);

    localparam int unsigned REFRAC_W = idx_w(REFRAC + 1);

    typedef logic signed [WEIGHT_SIZE-1:0] weight_t;
    typedef logic signed [POT_SIZE-1:0]    pot_t;
    typedef logic [REFRAC_W-1:0]           refrac_t;

    localparam logic [IW-1:0] I_LAST  = IW'(NUM_INPUTS - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(NUM_OUTPUTS - 1);
    localparam pot_t          RESET_V = pot_t'(RESET);

    lif_state_e             state_q, state_d;
    logic [NUM_INPUTS-1:0]  spike_in_q;
    logic [NW-1:0]          n_q;
    logic [IW-1:0]          i_q;
    pot_t                   sum_q;
    logic [NUM_OUTPUTS-1:0] fired_q, fired_d;
    logic [NUM_OUTPUTS-1:0] spike_out_q;
    pot_t                   v_q      [NUM_OUTPUTS];
    refrac_t                refrac_q [NUM_OUTPUTS];
    weight_t                w_q      [NUM_OUTPUTS][NUM_INPUTS];

    weight_t w_sel;
    pot_t    addend;
    pot_t    upd_v;
    refrac_t upd_refrac;
    logic    upd_spike;
    logic    wr_ok;

    assign step_ready  = (state_q == StIdle);
    assign spike_valid = (state_q == StDone);
    assign spike_out   = spike_out_q;
    assign wr_ok       = wr_en && (32'(wr_neuron) < NUM_OUTPUTS) && (32'(wr_input) < NUM_INPUTS);

    // Sequencer next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (step_valid) state_d = StAccum;
            StAccum:  if (i_q == I_LAST) state_d = StUpdate;
            StUpdate: state_d = (n_q == N_LAST) ? StDone : StAccum;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Current synapse contribution, gated by its latched input spike.
    always_comb begin
        w_sel  = w_q[n_q][i_q];
        addend = spike_in_q[i_q] ? pot_t'(w_sel) : '0;
    end

    // Spikes collected so far including the neuron being updated now.
    always_comb begin
        fired_d      = fired_q;
        fired_d[n_q] = upd_spike;
    end

    lif_update #(
        .POT_SIZE   (POT_SIZE),
        .THRESH     (THRESH),
        .RESET      (RESET),
        .LEAK_SHIFT (LEAK_SHIFT),
        .REFRAC     (REFRAC),
        .WTA        (WTA),
        .REFRAC_W   (REFRAC_W)
    ) u_update (
        .v           (v_q[n_q]),
        .sum         (sum_q),
        .refrac      (refrac_q[n_q]),
        .inhibit     (|fired_q),
        .v_next      (upd_v),
        .refrac_next (upd_refrac),
        .spike       (upd_spike)
    );

    // Datapath: weight writes, accumulation and per-neuron state updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            spike_in_q  <= '0;
            n_q         <= '0;
            i_q         <= '0;
            sum_q       <= '0;
            fired_q     <= '0;
            spike_out_q <= '0;
            for (int n = 0; n < NUM_OUTPUTS; n++) begin
                v_q[n]      <= RESET_V;
                refrac_q[n] <= '0;
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    w_q[n][i] <= '0;
                end
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    // A write in the accept cycle lands before the first ACCUM read.
                    if (wr_ok) begin
                        w_q[wr_neuron][wr_input] <= wr_data;
                    end
                    if (step_valid) begin
                        spike_in_q <= spike_in;
                        n_q        <= '0;
                        i_q        <= '0;
                        sum_q      <= '0;
                        fired_q    <= '0;
                    end
                end
                StAccum: begin
                    // Width rule on POT_SIZE guarantees the running sum cannot overflow.
                    sum_q <= sum_q + addend;
                    i_q   <= i_q + IW'(1);
                end
                StUpdate: begin
                    v_q[n_q]      <= upd_v;
                    refrac_q[n_q] <= upd_refrac;
                    fired_q       <= fired_d;
                    i_q           <= '0;
                    sum_q         <= '0;
                    if (n_q == N_LAST) begin
                        spike_out_q <= fired_d;
                    end else begin
                        n_q <= n_q + NW'(1);
                    end
                end
                StDone: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_layer_tm.sv
// Bench for lif_layer_tm: two configurations, constant tables plus a step-level reference model.
module tb_lif_layer_tm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst = 2'b11;
    logic [1:0] sv  = 2'b00;
    logic [1:0] we  = 2'b00;
    logic [3:0] si  = '0;
    logic [1:0] wn  = '0;
    logic [1:0] wi  = '0;
    logic [7:0] wd  = '0;

    logic       rdy_a, rdy_b, val_a, val_b;
    logic [1:0] so_a;
    logic [2:0] so_b;

    // Config A: plain IF with refractory period.
    lif_layer_tm #(
        .NUM_INPUTS(4), .NUM_OUTPUTS(2), .WEIGHT_SIZE(8), .POT_SIZE(16), .THRESH(10),
        .RESET(0), .LEAK_SHIFT(0), .REFRAC(2), .WTA(0)
    ) dut_a (
        .clk(clk), .rst(rst[0]), .step_valid(sv[0]), .step_ready(rdy_a), .spike_in(si),
        .spike_out(so_a), .spike_valid(val_a), .wr_en(we[0]), .wr_neuron(wn[0:0]),
        .wr_input(wi), .wr_data(wd)
    );

    // Config B: narrow saturating potential, leak, WTA, nonzero reset level.
    lif_layer_tm #(
        .NUM_INPUTS(4), .NUM_OUTPUTS(3), .WEIGHT_SIZE(6), .POT_SIZE(8), .THRESH(70),
        .RESET(3), .LEAK_SHIFT(1), .REFRAC(1), .WTA(1)
    ) dut_b (
        .clk(clk), .rst(rst[1]), .step_valid(sv[1]), .step_ready(rdy_b), .spike_in(si),
        .spike_out(so_b), .spike_valid(val_b), .wr_en(we[1]), .wr_neuron(wn),
        .wr_input(wi), .wr_data(wd[5:0])
    );

    int c_no  [2] = '{2, 3};
    int c_ws  [2] = '{8, 6};
    int c_ps  [2] = '{16, 8};
    int c_th  [2] = '{10, 70};
    int c_rv  [2] = '{0, 3};
    int c_lk  [2] = '{0, 1};
    int c_rf  [2] = '{2, 1};
    int c_wta [2] = '{0, 1};

    int mv [2][3];
    int mr [2][3];
    int mw [2][3][4];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] spk;
        logic [1:0] exp_out;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic logic get_rdy(input int s);
        return (s == 0) ? rdy_a : rdy_b;
    endfunction

    function automatic logic get_val(input int s);
        return (s == 0) ? val_a : val_b;
    endfunction

    function automatic logic [2:0] get_out(input int s);
        return (s == 0) ? {1'b0, so_a} : so_b;
    endfunction

    function automatic void model_reset(input int s);
        for (int n = 0; n < 3; n++) begin
            mv[s][n] = c_rv[s];
            mr[s][n] = 0;
            for (int i = 0; i < 4; i++) mw[s][n][i] = 0;
        end
    endfunction

    function automatic void model_write(input int s, input int n, input int i,
                                        input logic [7:0] d);
        int v;
        v = int'(d) & ((1 << c_ws[s]) - 1);
        if (v >= (1 << (c_ws[s] - 1))) v -= (1 << c_ws[s]);
        if (n < c_no[s] && i < 4) mw[s][n][i] = v;
    endfunction

    // One whole timestep of the layer, straight from the neuron rules.
    function automatic int model_step(input int s, input logic [3:0] spk);
        int out;
        int fired;
        int sum;
        int lk;
        int vp;
        int lo;
        int hi;
        out   = 0;
        fired = 0;
        lo    = -(1 << (c_ps[s] - 1));
        hi    = (1 << (c_ps[s] - 1)) - 1;
        for (int n = 0; n < c_no[s]; n++) begin
            sum = 0;
            for (int i = 0; i < 4; i++) if (spk[i]) sum += mw[s][n][i];
            if (mr[s][n] > 0) begin
                mr[s][n]--;
                mv[s][n] = c_rv[s];
            end else if (c_wta[s] != 0 && fired != 0) begin
                mv[s][n] = c_rv[s];
            end else begin
                lk = (c_lk[s] == 0) ? 0 : (mv[s][n] >>> c_lk[s]);
                vp = mv[s][n] - lk + sum;
                if (vp > hi) vp = hi;
                if (vp < lo) vp = lo;
                if (vp >= c_th[s]) begin
                    out |= (1 << n);
                    fired = 1;
                    mv[s][n] = c_rv[s];
                    mr[s][n] = c_rf[s];
                end else begin
                    mv[s][n] = vp;
                end
            end
        end
        return out;
    endfunction

    task automatic dut_reset(input int s);
        @(negedge clk);
        rst[s] = 1'b1;
        sv[s]  = 1'b0;
        we[s]  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst[s] = 1'b0;
        model_reset(s);
    endtask

    task automatic dut_write(input int s, input logic [1:0] n, input logic [1:0] i,
                             input logic [7:0] d);
        @(negedge clk);
        wn = n; wi = i; wd = d; we[s] = 1'b1;
        @(negedge clk);
        we[s] = 1'b0;
        model_write(s, int'(n), int'(i), d);
    endtask

    // mode 0: plain step; 1: weight write in the accept cycle; 2: write during ACCUM.
    task automatic run_step(input int s, input logic [3:0] spk, input int mode,
                            input logic [1:0] n, input logic [1:0] i, input logic [7:0] d,
                            output int out);
        int lat;
        @(negedge clk);
        check("ready_idle", get_rdy(s), 1);
        si = spk;
        sv[s] = 1'b1;
        if (mode == 1) begin
            wn = n; wi = i; wd = d; we[s] = 1'b1;
        end
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            sv[s] = 1'b0;
            we[s] = 1'b0;
            lat++;
            if (mode == 2 && lat == 2) begin
                wn = n; wi = i; wd = d; we[s] = 1'b1;
            end
        end while (!get_val(s) && lat < 100);
        check("latency", lat, c_no[s] * 5 + 1);
        check("ready_in_done", get_rdy(s), 0);
        out = int'(get_out(s));
        @(negedge clk);
        check("ready_after_done", {get_rdy(s), get_val(s)}, 2'b10);
        if (mode == 1) model_write(s, int'(n), int'(i), d);
    endtask

    // expv < 0 compares against the model; otherwise against the given constant.
    task automatic step_check(input int s, input logic [3:0] spk, input int mode,
                              input logic [1:0] n, input logic [1:0] i, input logic [7:0] d,
                              input int expv, input string name);
        int out;
        int mexp;
        run_step(s, spk, mode, n, i, d, out);
        mexp = model_step(s, spk);
        check(name, out, (expv < 0) ? mexp : expv);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        int r;
        int mode;
        int out;
        logic [1:0] rn;
        logic [1:0] ri;
        logic [7:0] rd;
        logic [3:0] rs;

        tbl[0] = '{4'b1111, 2'b11};
        tbl[1] = '{4'b1111, 2'b00};
        tbl[2] = '{4'b1111, 2'b00};
        tbl[3] = '{4'b1111, 2'b11};
        tbl[4] = '{4'b0000, 2'b00};
        tbl[5] = '{4'b0000, 2'b00};
        tbl[6] = '{4'b0111, 2'b00};
        tbl[7] = '{4'b0001, 2'b11};

        repeat (3) @(negedge clk);
        rst = 2'b00;
        model_reset(0);
        model_reset(1);
        check("rst_ready_a", rdy_a, 1);
        check("rst_valid_a", val_a, 0);
        check("rst_out_a", so_a, 0);
        check("rst_ready_b", rdy_b, 1);
        check("rst_valid_b", val_b, 0);
        check("rst_out_b", so_b, 0);

        // ---- Config A ----
        step_check(0, 4'b1111, 0, 0, 0, 0, 0, "zero_weights_after_rst");
        for (int n = 0; n < 2; n++)
            for (int i = 0; i < 4; i++) dut_write(0, 2'(n), 2'(i), 8'd3);
        for (int k = 0; k < 8; k++)
            step_check(0, tbl[k].spk, 0, 0, 0, 0, int'(tbl[k].exp_out), "table_a");

        step_check(0, 4'b0000, 0, 0, 0, 0, -1, "refrac_idle");
        step_check(0, 4'b0000, 0, 0, 0, 0, -1, "refrac_idle");
        step_check(0, 4'b1111, 2, 2'd0, 2'd0, 8'hCE, 3, "accum_write_dropped");
        step_check(0, 4'b0000, 0, 0, 0, 0, -1, "refrac_idle");
        step_check(0, 4'b0000, 0, 0, 0, 0, -1, "refrac_idle");
        step_check(0, 4'b1111, 0, 0, 0, 0, 3, "next_step_old_weight");
        step_check(0, 4'b0000, 0, 0, 0, 0, -1, "refrac_idle");
        step_check(0, 4'b0000, 0, 0, 0, 0, -1, "refrac_idle");
        step_check(0, 4'b1111, 1, 2'd0, 2'd0, 8'hCE, 2, "write_with_accept");

        // Reset in the middle of ACCUM.
        @(negedge clk);
        si = 4'b1111;
        sv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sv[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        model_reset(0);
        check("ready_after_mid_rst", {rdy_a, val_a}, 2'b10);
        check("out_cleared_mid_rst", so_a, 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (val_a) seen++;
        end
        check("no_valid_after_abort", seen, 0);
        step_check(0, 4'b1111, 0, 0, 0, 0, 0, "weights_cleared_mid_rst");

        // ---- Config B ----
        dut_reset(1);
        dut_write(1, 2'd0, 2'd0, 8'd31);
        // With leak the potential settles at 62, below 70; without leak it fires on step 3.
        for (int k = 0; k < 6; k++) step_check(1, 4'b0001, 0, 0, 0, 0, 0, "leak_no_fire");
        for (int i = 0; i < 4; i++) dut_write(1, 2'd0, 2'(i), 8'hE0);
        for (int k = 0; k < 3; k++) step_check(1, 4'b1111, 0, 0, 0, 0, 0, "neg_drive");
        for (int i = 0; i < 4; i++) dut_write(1, 2'd0, 2'(i), 8'd31);
        // From a clamped -128 the potential reaches 60, then saturates at 127 and fires.
        step_check(1, 4'b1111, 0, 0, 0, 0, 0, "neg_saturated");
        step_check(1, 4'b1111, 0, 0, 0, 0, 1, "pos_saturated_fire");
        dut_write(1, 2'd3, 2'd0, 8'd31);
        step_check(1, 4'b1111, 0, 0, 0, 0, -1, "oob_write_dropped");

        dut_reset(1);
        for (int n = 0; n < 2; n++)
            for (int i = 0; i < 4; i++) dut_write(1, 2'(n), 2'(i), 8'd31);
        step_check(1, 4'b1111, 0, 0, 0, 0, 1, "wta_lowest_wins");
        step_check(1, 4'b0000, 0, 0, 0, 0, -1, "wta_after");
        step_check(1, 4'b1111, 0, 0, 0, 0, -1, "wta_after");

        // ---- Randomized against the model ----
        for (int s = 0; s < 2; s++) begin
            dut_reset(s);
            for (int k = 0; k < 60; k++) begin
                r  = $urandom_range(0, 9);
                rn = 2'($urandom_range(0, (s == 0) ? 1 : 3));
                ri = 2'($urandom_range(0, 3));
                rd = (s == 0) ? (8'($urandom_range(0, 16)) - 8'd6) : 8'($urandom_range(0, 63));
                rs = 4'($urandom_range(0, 15));
                if (r < 3) begin
                    dut_write(s, rn, ri, rd);
                end else begin
                    mode = (r == 3) ? 1 : ((r == 4) ? 2 : 0);
                    run_step(s, rs, mode, rn, ri, rd, out);
                    check("rand_spikes", out, model_step(s, rs));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
